// File: rtl/ps2_cmd_pkg.sv
// Shared command codes, scancodes, parser states and key-map helpers for ps2_cmd_decoder.
// The alias key map is compiled in only when KEYMAP_ALT_EN is defined.
package ps2_cmd_pkg;

  localparam int NUM_CMDS = 5;

  typedef enum logic [2:0] {
    CMD_LEFT   = 3'd0,
    CMD_RIGHT  = 3'd1,
    CMD_ROTATE = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_DROP   = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic hit;
    cmd_e cmd;
  } key_map_t;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ALT_A = 8'h1C;
  localparam logic [7:0] SC_ALT_D = 8'h23;
  localparam logic [7:0] SC_ALT_W = 8'h1D;
  localparam logic [7:0] SC_ALT_S = 8'h1B;

  // Codes accepted without an E0 prefix.
  function automatic key_map_t map_plain(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b0;
    m.cmd = CMD_LEFT;
    case (code)
      SC_SPACE: begin m.hit = 1'b1; m.cmd = CMD_DROP;   end
`ifdef KEYMAP_ALT_EN
      SC_ALT_A: begin m.hit = 1'b1; m.cmd = CMD_LEFT;   end
      SC_ALT_D: begin m.hit = 1'b1; m.cmd = CMD_RIGHT;  end
      SC_ALT_W: begin m.hit = 1'b1; m.cmd = CMD_ROTATE; end
      SC_ALT_S: begin m.hit = 1'b1; m.cmd = CMD_DOWN;   end
`endif
      default:  begin m.hit = 1'b0; m.cmd = CMD_LEFT;   end
    endcase
    return m;
  endfunction

  function automatic key_map_t map_ext(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b0;
    m.cmd = CMD_LEFT;
    case (code)
      SC_LEFT:  begin m.hit = 1'b1; m.cmd = CMD_LEFT;   end
      SC_RIGHT: begin m.hit = 1'b1; m.cmd = CMD_RIGHT;  end
      SC_UP:    begin m.hit = 1'b1; m.cmd = CMD_ROTATE; end
      SC_DOWN:  begin m.hit = 1'b1; m.cmd = CMD_DOWN;   end
      default:  begin m.hit = 1'b0; m.cmd = CMD_LEFT;   end
    endcase
    return m;
  endfunction

  function automatic logic is_repeat_cmd(input cmd_e c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO: head is visible whenever valid; a full push without a
// same-cycle pop is dropped and flagged by a one-cycle overflow pulse.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_s;
  logic             valid_r, overflow_r;
  logic             pop_s, full_s, wr_en_s, drop_s;

  assign pop_s   = valid_r && pop_ready;
  assign full_s  = (count_r == FULL_CNT);
  assign wr_en_s = push && (!full_s || pop_s);
  assign drop_s  = push && full_s && !pop_s;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Storage, pointers and registered status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= CNT_ZERO;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r    <= count_s;
      valid_r    <= (count_s != CNT_ZERO);
      overflow_r <= drop_s;
    end
  end

  assign valid    = valid_r;
  assign head     = mem_r[rd_ptr_r];
  assign overflow = overflow_r;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 byte stream to game-command decoder: prefix parser, held-key bitmap, auto-repeat
// timer and command FIFO. Define KEYMAP_ALT_EN to add the A/D/W/S aliases.
module ps2_cmd_decoder
  import ps2_cmd_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int REPEAT_DELAY_MS = 250,
  parameter int REPEAT_RATE_MS  = 50,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [7:0]    key_data,
  input  logic          key_strobe,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [2:0]    cmd_code,
  output logic [4:0]    held,
  output logic          overflow
);

  localparam int DELAY_CYC = REPEAT_DELAY_MS * (CLK_HZ / 1000);
  localparam int RATE_CYC  = REPEAT_RATE_MS * (CLK_HZ / 1000);
  localparam int MAX_CYC   = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int TW        = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] DELAY_LD   = TW'(DELAY_CYC);
  localparam logic [TW-1:0] RATE_LD    = TW'(RATE_CYC);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);

  parse_state_e state_r, state_s;
  key_map_t     plain_s, ext_s;
  logic         make_s, brk_s;
  cmd_e         key_s;
  logic [NUM_CMDS-1:0] key_oh_s, held_r, held_s;
  logic         key_held_s, make_new_s, make_rep_s, brk_tgt_s, expire_s;

  logic [TW-1:0] timer_r, timer_s;
  logic          timer_act_r, timer_act_s;
  cmd_e          target_r, target_s;
  logic          pend_r, pend_s;
  cmd_e          pend_code_r, pend_code_s;
  logic          push_s;
  logic [2:0]    push_code_s;

  assign plain_s = map_plain(key_data);
  assign ext_s   = map_ext(key_data);

  // Prefix parser: classifies each strobed byte as make, break or neither.
  always_comb begin
    state_s = state_r;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    key_s   = CMD_LEFT;
    if (key_strobe) begin
      case (state_r)
        ST_IDLE: begin
          if (key_data == SC_E0)      state_s = ST_EXT;
          else if (key_data == SC_F0) state_s = ST_BRK;
          else if (plain_s.hit) begin
            make_s = 1'b1;
            key_s  = plain_s.cmd;
          end else state_s = ST_IDLE;
        end
        ST_EXT: begin
          if (key_data == SC_F0)      state_s = ST_EXT_BRK;
          else if (key_data == SC_E0) state_s = ST_EXT;
          else begin
            state_s = ST_IDLE;
            if (ext_s.hit) begin
              make_s = 1'b1;
              key_s  = ext_s.cmd;
            end else make_s = 1'b0;
          end
        end
        ST_BRK: begin
          state_s = ST_IDLE;
          if (plain_s.hit) begin
            brk_s = 1'b1;
            key_s = plain_s.cmd;
          end else brk_s = 1'b0;
        end
        ST_EXT_BRK: begin
          state_s = ST_IDLE;
          if (ext_s.hit) begin
            brk_s = 1'b1;
            key_s = ext_s.cmd;
          end else brk_s = 1'b0;
        end
        default: state_s = ST_IDLE;
      endcase
    end else state_s = state_r;
  end

  assign key_oh_s   = NUM_CMDS'(1) << key_s;
  assign key_held_s = |(held_r & key_oh_s);
  assign make_new_s = make_s && !key_held_s;
  assign make_rep_s = make_new_s && is_repeat_cmd(key_s);
  assign brk_tgt_s  = brk_s && timer_act_r && (key_s == target_r);
  // Releasing the target in its expiry cycle cancels that repeat.
  assign expire_s   = timer_act_r && (timer_r <= TIMER_ONE) && !brk_tgt_s;

  // Push arbitration: fresh make first, then a deferred expiry, then a live expiry.
  always_comb begin
    push_s      = 1'b0;
    push_code_s = CMD_LEFT;
    pend_s      = pend_r;
    pend_code_s = pend_code_r;
    if (make_new_s) begin
      push_s      = 1'b1;
      push_code_s = key_s;
      if (expire_s && !make_rep_s) begin
        pend_s      = 1'b1;
        pend_code_s = target_r;
      end else pend_s = pend_r;
    end else if (pend_r) begin
      push_s      = 1'b1;
      push_code_s = pend_code_r;
      pend_s      = expire_s;
      if (expire_s) pend_code_s = target_r;
      else          pend_code_s = pend_code_r;
    end else if (expire_s) begin
      push_s      = 1'b1;
      push_code_s = target_r;
    end else push_s = 1'b0;
  end

  // Repeat timer and held bitmap next state.
  always_comb begin
    timer_s     = timer_r;
    timer_act_s = timer_act_r;
    target_s    = target_r;
    held_s      = held_r;
    if (make_rep_s) begin
      timer_act_s = 1'b1;
      target_s    = key_s;
      timer_s     = DELAY_LD;
    end else if (brk_tgt_s) begin
      timer_act_s = 1'b0;
      timer_s     = TIMER_ZERO;
    end else if (expire_s) begin
      timer_s = RATE_LD;
    end else if (timer_act_r && (timer_r != TIMER_ZERO)) begin
      timer_s = timer_r - TIMER_ONE;
    end else timer_s = timer_r;
    if (make_s)     held_s = held_r | key_oh_s;
    else if (brk_s) held_s = held_r & ~key_oh_s;
    else            held_s = held_r;
  end

  // Parser, timer and bitmap state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      held_r      <= '0;
      timer_r     <= TIMER_ZERO;
      timer_act_r <= 1'b0;
      target_r    <= CMD_LEFT;
      pend_r      <= 1'b0;
      pend_code_r <= CMD_LEFT;
    end else begin
      state_r     <= state_s;
      held_r      <= held_s;
      timer_r     <= timer_s;
      timer_act_r <= timer_act_s;
      target_r    <= target_s;
      pend_r      <= pend_s;
      pend_code_r <= pend_code_s;
    end
  end

  cmd_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_s),
    .push_data (push_code_s),
    .pop_ready (cmd_ready),
    .valid     (cmd_valid),
    .head      (cmd_code),
    .overflow  (overflow)
  );

  assign held = held_r;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed table, multi-cycle sequences and a
// randomized run against an event-level reference model (1 ms = 1 cycle, delay 4, rate 2).
module tb_ps2_cmd_decoder;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_strobe = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] held;
  logic       overflow;

  ps2_cmd_decoder #(
    .CLK_HZ(1000), .REPEAT_DELAY_MS(4), .REPEAT_RATE_MS(2), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_strobe(key_strobe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .held(held), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending commands plus absolute cycle of the next repeat.
  int mq[$];
  bit [4:0] m_held;
  bit m_ext, m_brk, m_rep_on, m_pend, m_ovf;
  int m_rep_key, m_next_fire, m_pend_code, mc;
  int pops[$];
  int pop_cyc[$];
  int ovf_seen;

  typedef struct {
    logic [7:0] b [3];
    int         n;
    logic [4:0] exp_held;
    int         exp_cmd;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int map_plain_m(input logic [7:0] b);
    if (b == 8'h29) return 4;
`ifdef KEYMAP_ALT_EN
    if (b == 8'h1C) return 0;
    if (b == 8'h23) return 1;
    if (b == 8'h1D) return 2;
    if (b == 8'h1B) return 3;
`endif
    return -1;
  endfunction

  function automatic int map_ext_m(input logic [7:0] b);
    if (b == 8'h6B) return 0;
    if (b == 8'h74) return 1;
    if (b == 8'h75) return 2;
    if (b == 8'h72) return 3;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_held = '0; m_ext = 0; m_brk = 0; m_rep_on = 0; m_pend = 0; m_ovf = 0;
    m_rep_key = 0; m_next_fire = 0; m_pend_code = 0;
  endtask

  task automatic model_step(input logic stb, input logic [7:0] b, input logic rdy);
    int ev, k, pc, ec, push_code;
    bit newmake, brk_tgt, fire, isrep;
    ev = 0; k = 0; push_code = -1;
    pc = map_plain_m(b);
    ec = map_ext_m(b);
    if (stb) begin
      if (m_ext && m_brk) begin
        if (ec >= 0) begin ev = 2; k = ec; end
        m_ext = 0; m_brk = 0;
      end else if (m_brk) begin
        if (pc >= 0) begin ev = 2; k = pc; end
        m_brk = 0;
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
          if (ec >= 0) begin ev = 1; k = ec; end
          m_ext = 0;
        end
      end else begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (pc >= 0) begin ev = 1; k = pc; end
      end
    end
    isrep   = (k != 2) && (k != 4);
    newmake = (ev == 1) && !m_held[k];
    brk_tgt = (ev == 2) && m_rep_on && (k == m_rep_key);
    fire    = m_rep_on && (mc == m_next_fire) && !brk_tgt;
    if (newmake) begin
      push_code = k;
      if (fire && !isrep) begin m_pend = 1; m_pend_code = m_rep_key; end
    end else if (m_pend) begin
      push_code = m_pend_code;
      m_pend = fire;
      if (fire) m_pend_code = m_rep_key;
    end else if (fire) push_code = m_rep_key;
    if (newmake && isrep) begin
      m_rep_on = 1; m_rep_key = k; m_next_fire = mc + 4;
    end else if (brk_tgt) m_rep_on = 0;
    else if (fire) m_next_fire = mc + 2;
    if (ev == 1) m_held[k] = 1;
    if (ev == 2) m_held[k] = 0;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    m_ovf = 0;
    if (push_code >= 0) begin
      if (mq.size() < 4) mq.push_back(push_code);
      else m_ovf = 1;
    end
    mc++;
  endtask

  // One clock: compare against the model, record pops, then drive the next inputs.
  task automatic cyc(input logic stb, input logic [7:0] b, input logic rdy);
    @(negedge clock);
    check("valid", int'(cmd_valid), int'(mq.size() > 0));
    if (mq.size() > 0) check("code", int'(cmd_code), mq[0]);
    check("held", int'(held), int'(m_held));
    check("overflow", int'(overflow), int'(m_ovf));
    if (cmd_valid && rdy) begin
      pops.push_back(int'(cmd_code));
      pop_cyc.push_back(mc);
    end
    if (overflow) ovf_seen++;
    key_strobe = stb; key_data = b; cmd_ready = rdy;
    model_step(stb, b, rdy);
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    cyc(1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    key_strobe = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_held", int'(held), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clock);
    resetn = 1'b1;
    pops.delete(); pop_cyc.delete(); ovf_seen = 0;
  endtask

  initial begin
    logic [7:0] pool [12];
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h12};
    tbl[0]  = '{'{8'h29, 8'h00, 8'h00}, 1, 5'b10000, 4};
    tbl[1]  = '{'{8'h29, 8'h00, 8'h00}, 1, 5'b10000, -1};
    tbl[2]  = '{'{8'hE0, 8'h75, 8'h00}, 2, 5'b10100, 2};
    tbl[3]  = '{'{8'hE0, 8'hE0, 8'h75}, 3, 5'b10100, -1};
    tbl[4]  = '{'{8'hF0, 8'h29, 8'h00}, 2, 5'b00100, -1};
    tbl[5]  = '{'{8'hE0, 8'hF0, 8'h75}, 3, 5'b00000, -1};
    tbl[6]  = '{'{8'h12, 8'h00, 8'h00}, 1, 5'b00000, -1};
    tbl[7]  = '{'{8'hF0, 8'h75, 8'h00}, 2, 5'b00000, -1};
    tbl[8]  = '{'{8'hE0, 8'h29, 8'h00}, 2, 5'b00000, -1};
    tbl[9]  = '{'{8'h29, 8'h00, 8'h00}, 1, 5'b10000, 4};
    tbl[10] = '{'{8'hF0, 8'h29, 8'h00}, 2, 5'b00000, -1};
    mc = 0;
    model_reset();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      pops.delete();
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].b[j], 1'b1);
      idle(3, 1'b1);
      check($sformatf("tbl%0d_held", i), int'(held), int'(tbl[i].exp_held));
      check($sformatf("tbl%0d_npop", i), pops.size(), (tbl[i].exp_cmd >= 0) ? 1 : 0);
      if (tbl[i].exp_cmd >= 0 && pops.size() > 0)
        check($sformatf("tbl%0d_cmd", i), pops[0], tbl[i].exp_cmd);
    end

    // Press and promptly release LEFT.
    do_reset();
    send(8'hE0, 1'b1); send(8'h6B, 1'b1); send(8'hE0, 1'b1);
    check("left_held", int'(held), 1);
    send(8'hF0, 1'b1); send(8'h6B, 1'b1);
    idle(8, 1'b1);
    check("left_npop", pops.size(), 1);
    if (pops.size() > 0) check("left_code", pops[0], 0);
    check("left_released", int'(held), 0);

    // DROP never repeats.
    do_reset();
    send(8'h29, 1'b1);
    idle(20, 1'b1);
    check("drop_npop", pops.size(), 1);
    if (pops.size() > 0) check("drop_code", pops[0], 4);
    send(8'hF0, 1'b1); send(8'h29, 1'b1); idle(2, 1'b1);

    // RIGHT held: make, +4, then every 2 until the break.
    do_reset();
    send(8'hE0, 1'b1); send(8'h74, 1'b1);
    idle(10, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h74, 1'b1);
    idle(10, 1'b1);
    check("rpt_npop", pops.size(), 6);
    for (int i = 0; i < pops.size(); i++) check("rpt_code", pops[i], 1);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("rpt_gap", pop_cyc[i] - pop_cyc[i-1], (i == 1) ? 4 : 2);

    // Fill the FIFO with the consumer stalled.
    do_reset();
    send(8'hE0, 1'b0); send(8'h6B, 1'b0); send(8'hE0, 1'b0); send(8'h74, 1'b0);
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'hE0, 1'b0); send(8'h72, 1'b0);
    send(8'h29, 1'b0);
    idle(2, 1'b0);
    check("ovf_pulses", ovf_seen, 1);
    pops.delete();
    idle(8, 1'b1);
    check("fill_npop", int'(pops.size() >= 4), 1);
    for (int i = 0; i < 4 && i < pops.size(); i++) check("fill_order", pops[i], i);

    // Break of an unpressed key, then a fresh make.
    do_reset();
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h74, 1'b1);
    send(8'hE0, 1'b1); send(8'h74, 1'b1);
    idle(2, 1'b1);
    check("brk_unp_npop", pops.size(), 1);
    if (pops.size() > 0) check("brk_unp_code", pops[0], 1);
    check("brk_unp_held", int'(held), 5'b00010);

    // Reset with an E0 prefix pending: a lone 6B must then be ignored.
    send(8'hE0, 1'b1);
    do_reset();
    send(8'h6B, 1'b1);
    idle(3, 1'b1);
    check("rst_prefix_npop", pops.size(), 0);
    check("rst_prefix_held", int'(held), 0);
    send(8'h29, 1'b1);
    idle(2, 1'b1);
    check("rst_after_npop", pops.size(), 1);
    if (pops.size() > 0) check("rst_after_code", pops[0], 4);

    // Alias key shares the LEFT bit.
    do_reset();
    send(8'h1C, 1'b1);
`ifdef KEYMAP_ALT_EN
    send(8'hE0, 1'b1); send(8'h6B, 1'b1);
    idle(1, 1'b1);
    check("alias_npop", pops.size(), 1);
    if (pops.size() > 0) check("alias_code", pops[0], 0);
    check("alias_held", int'(held), 1);
`else
    idle(3, 1'b1);
    check("alias_npop", pops.size(), 0);
    check("alias_held", int'(held), 0);
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic stb, rdy;
      stb = ($urandom_range(0, 99) < 40);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(stb, pool[$urandom_range(0, 11)], rdy);
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
